// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem request, static backward-taken
// prediction, hold register for queue back-pressure, squash on redirect.
//
// Ports:
//   clk, rst                 clock, async active-low reset
//   imem_addr/rmask          fetch request (rmask=4'hf for one cycle)
//   imem_rdata/resp          fetch response (one-cycle pulse)
//   iq_full                  instruction queue back-pressure
//   iq_push/inst/pc/predict  push bundle into the instruction queue
//   flush, flush_pc          backend redirect
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        iq_full,
    output logic        iq_push,
    output logic [31:0] iq_inst,
    output logic [31:0] iq_pc,
    output logic        iq_predict,
    input  logic        flush,
    input  logic [31:0] flush_pc
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_SQUASH
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] b_imm;
    logic [31:0] next_pc;

    // The word being offered to the queue comes from the hold register
    // while back-pressured, otherwise straight from the memory response.
    always_comb begin
        iq_inst    = (state_q == S_HOLD) ? hold_q : imem_rdata;
        iq_pc      = pc_q;
        iq_predict = (iq_inst[6:0] == 7'b1100011) && iq_inst[31];
        b_imm      = {{19{iq_inst[31]}}, iq_inst[31], iq_inst[7],
                      iq_inst[30:25], iq_inst[11:8], 1'b0};
        next_pc    = iq_predict ? (pc_q + b_imm) : (pc_q + 32'd4);
        imem_addr  = {pc_q[31:2], 2'b00};
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hold_d     = hold_q;
        imem_rmask = 4'h0;
        iq_push    = 1'b0;
        unique case (state_q)
            S_REQ: begin
                // Gated by rst so nothing is requested while in reset.
                if (rst) begin
                    imem_rmask = 4'hf;
                end
                if (flush) begin
                    pc_d    = flush_pc;
                    state_d = S_SQUASH;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    pc_d    = flush_pc;
                    state_d = imem_resp ? S_REQ : S_SQUASH;
                end else if (imem_resp) begin
                    if (iq_full) begin
                        hold_d  = imem_rdata;
                        state_d = S_HOLD;
                    end else begin
                        iq_push = 1'b1;
                        pc_d    = next_pc;
                        state_d = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                if (flush) begin
                    pc_d    = flush_pc;
                    hold_d  = '0;
                    state_d = S_REQ;
                end else if (!iq_full) begin
                    iq_push = 1'b1;
                    pc_d    = next_pc;
                    state_d = S_REQ;
                end
            end
            S_SQUASH: begin
                // Keep tracking the newest redirect until the stale
                // response has drained.
                if (flush) begin
                    pc_d = flush_pc;
                end
                if (imem_resp) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a
// randomized run checked against a PC/prediction reference model.
module tb_fetch_stage;

    localparam logic [31:0] RPC = 32'h1eceb000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        iq_full;
    logic        iq_push;
    logic [31:0] iq_inst;
    logic [31:0] iq_pc;
    logic        iq_predict;
    logic        flush;
    logic [31:0] flush_pc;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc;

    fetch_stage #(.RESET_PC(RPC)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_rmask (imem_rmask),
        .imem_rdata (imem_rdata),
        .imem_resp  (imem_resp),
        .iq_full    (iq_full),
        .iq_push    (iq_push),
        .iq_inst    (iq_inst),
        .iq_pc      (iq_pc),
        .iq_predict (iq_predict),
        .flush      (flush),
        .flush_pc   (flush_pc)
    );

    always #5 clk = ~clk;

    function automatic logic model_pred(input logic [31:0] i);
        return (i[6:0] == 7'b1100011) && i[31];
    endfunction

    // Branch offset rebuilt with plain arithmetic on the field values.
    function automatic logic [31:0] model_next(input logic [31:0] i,
                                               input logic [31:0] pc);
        int off;
        if (!model_pred(i)) return pc + 32'd4;
        off = int'(i[11:8]) * 2 + int'(i[30:25]) * 32
            + int'(i[7]) * 2048 - int'(i[31]) * 4096;
        return pc + 32'(off);
    endfunction

    function automatic logic [31:0] waddr(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    // New cycle window: 1ns after the edge, inputs back to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        imem_resp = 1'b0;
        flush     = 1'b0;
        iq_full   = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        exp_pc = RPC;
    endtask

    task automatic test_reset();
        #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            imem_resp = 1'b1;
            #1;
            checks++;
            if (imem_rmask !== 4'h0 || iq_push !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle: rmask=%h push=%b want 0/0",
                         imem_rmask, iq_push);
            end
        end
        tick();
        rst        = 1'b1;
        imem_resp  = 1'b1;
        imem_rdata = 32'h00000013;
        #1;
        checks++;
        if ({imem_rmask, imem_addr, iq_push} !== {4'hf, RPC, 1'b0}) begin
            errors++;
            $display("FAIL first_req: rmask=%h addr=%h push=%b want f %h 0",
                     imem_rmask, imem_addr, iq_push, RPC);
        end
        exp_pc = RPC;
    endtask

    task automatic test_basic();
        logic [31:0] w [3];
        logic [31:0] a [3];
        w = '{32'h00000013, 32'h00000013, 32'hfe000ee3};
        a = '{32'h1eceb004, 32'h1eceb008, 32'h1eceb004};
        for (int i = 0; i < 3; i++) begin
            tick();
            imem_resp  = 1'b1;
            imem_rdata = w[i];
            #1;
            checks++;
            if ({iq_push, iq_inst, iq_pc, iq_predict} !==
                {1'b1, w[i], exp_pc, (i == 2)}) begin
                errors++;
                $display("FAIL basic_push%0d: push=%b inst=%h pc=%h pr=%b want pc %h",
                         i, iq_push, iq_inst, iq_pc, iq_predict, exp_pc);
            end
            exp_pc = model_next(w[i], exp_pc);
            tick();
            #1;
            checks++;
            if ({imem_rmask, imem_addr} !== {4'hf, a[i]}) begin
                errors++;
                $display("FAIL basic_next%0d: rmask=%h addr=%h want f %h",
                         i, imem_rmask, imem_addr, a[i]);
            end
        end
    endtask

    task automatic test_forward_branch();
        do_reset();
        tick();
        imem_resp  = 1'b1;
        imem_rdata = 32'h00000463;
        #1;
        checks++;
        if ({iq_push, iq_pc, iq_predict} !== {1'b1, RPC, 1'b0}) begin
            errors++;
            $display("FAIL fwd_branch: push=%b pc=%h pr=%b want 1 %h 0",
                     iq_push, iq_pc, iq_predict, RPC);
        end
        tick();
        #1;
        checks++;
        if (imem_addr !== 32'h1eceb004) begin
            errors++;
            $display("FAIL fwd_next: addr=%h want 1eceb004", imem_addr);
        end
        exp_pc = 32'h1eceb004;
    endtask

    task automatic test_full_hold();
        logic [31:0] w;
        w = 32'h00a00093;
        tick();
        imem_resp  = 1'b1;
        imem_rdata = w;
        iq_full    = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                tick();
                imem_rdata = 32'hdeadbeef;
                iq_full    = 1'b1;
                #1;
            end
            checks++;
            if (iq_push !== 1'b0 || imem_rmask !== 4'h0) begin
                errors++;
                $display("FAIL hold_wait%0d: push=%b rmask=%h want 0 0",
                         i, iq_push, imem_rmask);
            end
        end
        tick();
        #1;
        checks++;
        if ({iq_push, iq_inst, iq_pc} !== {1'b1, w, exp_pc}) begin
            errors++;
            $display("FAIL hold_push: push=%b inst=%h pc=%h want 1 %h %h",
                     iq_push, iq_inst, iq_pc, w, exp_pc);
        end
        exp_pc = exp_pc + 32'd4;
        tick();
        #1;
        checks++;
        if (imem_addr !== exp_pc) begin
            errors++;
            $display("FAIL hold_next: addr=%h want %h", imem_addr, exp_pc);
        end
    endtask

    task automatic test_flush_wait();
        tick();
        flush    = 1'b1;
        flush_pc = 32'h1eceb100;
        #1;
        tick();
        tick();
        tick();
        imem_resp  = 1'b1;
        imem_rdata = 32'h00000013;
        #1;
        checks++;
        if (iq_push !== 1'b0) begin
            errors++;
            $display("FAIL flush_wait_push: push=%b want 0", iq_push);
        end
        tick();
        #1;
        checks++;
        if ({imem_rmask, imem_addr} !== {4'hf, 32'h1eceb100}) begin
            errors++;
            $display("FAIL flush_wait_next: rmask=%h addr=%h want f 1eceb100",
                     imem_rmask, imem_addr);
        end
        tick();
        imem_resp  = 1'b1;
        flush      = 1'b1;
        flush_pc   = 32'h1eceb100;
        #1;
        checks++;
        if (iq_push !== 1'b0) begin
            errors++;
            $display("FAIL flush_resp_push: push=%b want 0", iq_push);
        end
        tick();
        #1;
        checks++;
        if ({imem_rmask, imem_addr} !== {4'hf, 32'h1eceb100}) begin
            errors++;
            $display("FAIL flush_resp_next: rmask=%h addr=%h want f 1eceb100",
                     imem_rmask, imem_addr);
        end
        exp_pc = 32'h1eceb100;
    endtask

    task automatic test_flush_squash();
        tick();
        flush    = 1'b1;
        flush_pc = 32'h1eceb100;
        #1;
        tick();
        flush    = 1'b1;
        flush_pc = 32'h1eceb200;
        #1;
        tick();
        imem_resp  = 1'b1;
        imem_rdata = 32'h00000013;
        #1;
        checks++;
        if (iq_push !== 1'b0) begin
            errors++;
            $display("FAIL squash_push: push=%b want 0", iq_push);
        end
        tick();
        #1;
        checks++;
        if ({imem_rmask, imem_addr} !== {4'hf, 32'h1eceb200}) begin
            errors++;
            $display("FAIL squash_next: rmask=%h addr=%h want f 1eceb200",
                     imem_rmask, imem_addr);
        end
        exp_pc = 32'h1eceb200;
    endtask

    task automatic test_reset_mid();
        tick();
        rst       = 1'b0;
        imem_resp = 1'b1;
        #1;
        checks++;
        if (imem_rmask !== 4'h0 || iq_push !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: rmask=%h push=%b want 0 0",
                     imem_rmask, iq_push);
        end
        tick();
        rst        = 1'b1;
        imem_resp  = 1'b1;
        imem_rdata = 32'h00000013;
        #1;
        checks++;
        if ({imem_rmask, imem_addr, iq_push} !== {4'hf, RPC, 1'b0}) begin
            errors++;
            $display("FAIL stale_resp: rmask=%h addr=%h push=%b want f %h 0",
                     imem_rmask, imem_addr, iq_push, RPC);
        end
        exp_pc = RPC;
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            w = 32'h00100093 + (32'(i) << 20);
            tick();
            imem_resp  = 1'b1;
            imem_rdata = w;
            #1;
            checks++;
            if ({iq_push, iq_inst, iq_pc} !== {1'b1, w, exp_pc}) begin
                errors++;
                $display("FAIL b2b_push%0d: push=%b inst=%h pc=%h want pc %h",
                         i, iq_push, iq_inst, iq_pc, exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
            tick();
            #1;
            checks++;
            if ({imem_rmask, imem_addr} !== {4'hf, exp_pc}) begin
                errors++;
                $display("FAIL b2b_req%0d: rmask=%h addr=%h want f %h",
                         i, imem_rmask, imem_addr, exp_pc);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] w, r, fp;
        int          lat, fc, mode;
        logic        pushed, hf;
        for (int it = 0; it < 200; it++) begin
            r = $urandom;
            w = ($urandom_range(0, 1) == 1) ? {r[31:7], 7'b1100011} : r;
            if (model_pred(w)) w[8] = 1'b0;
            r    = $urandom;
            fp   = {r[31:2], 2'b00};
            lat  = $urandom_range(0, 2);
            fc   = $urandom_range(0, 3);
            mode = $urandom_range(0, 5);
            if (mode > 3) mode = 0;
            if (mode == 2 && lat == 0) mode = 3;
            if (mode == 1) begin
                flush    = 1'b1;
                flush_pc = fp;
                #1;
                checks++;
                if (imem_rmask !== 4'hf) begin
                    errors++;
                    $display("FAIL rnd_req_flush: rmask=%h want f", imem_rmask);
                end
            end
            for (int i = 0; i < lat; i++) begin
                tick();
                if (mode == 2 && i == 0) begin
                    flush    = 1'b1;
                    flush_pc = fp;
                end
                #1;
                checks++;
                if (iq_push !== 1'b0 || imem_rmask !== 4'h0) begin
                    errors++;
                    $display("FAIL rnd_wait: push=%b rmask=%h want 0 0",
                             iq_push, imem_rmask);
                end
            end
            tick();
            imem_resp  = 1'b1;
            imem_rdata = w;
            iq_full    = (fc > 0);
            if (mode == 3) begin
                flush    = 1'b1;
                flush_pc = fp;
            end
            #1;
            pushed = (mode == 0 && fc == 0);
            checks++;
            if (pushed) begin
                if ({iq_push, iq_inst, iq_pc, iq_predict} !==
                    {1'b1, w, exp_pc, model_pred(w)}) begin
                    errors++;
                    $display("FAIL rnd_push: push=%b inst=%h pc=%h pr=%b want %h %h %b",
                             iq_push, iq_inst, iq_pc, iq_predict,
                             w, exp_pc, model_pred(w));
                end
            end else if (iq_push !== 1'b0) begin
                errors++;
                $display("FAIL rnd_nopush: push=%b want 0 mode=%0d", iq_push, mode);
            end
            if (mode == 0 && fc > 0) begin
                for (int k = 1; k < fc; k++) begin
                    tick();
                    iq_full = 1'b1;
                    #1;
                    checks++;
                    if (iq_push !== 1'b0) begin
                        errors++;
                        $display("FAIL rnd_hold: push=%b want 0", iq_push);
                    end
                end
                tick();
                hf = ($urandom_range(0, 2) == 0);
                if (hf) begin
                    flush    = 1'b1;
                    flush_pc = fp;
                end
                #1;
                checks++;
                if (hf) begin
                    if (iq_push !== 1'b0) begin
                        errors++;
                        $display("FAIL rnd_hold_flush: push=%b want 0", iq_push);
                    end
                    mode = 4;
                end else if ({iq_push, iq_inst, iq_pc, iq_predict} !==
                             {1'b1, w, exp_pc, model_pred(w)}) begin
                    errors++;
                    $display("FAIL rnd_hold_push: push=%b inst=%h pc=%h pr=%b want %h %h %b",
                             iq_push, iq_inst, iq_pc, iq_predict,
                             w, exp_pc, model_pred(w));
                end
                pushed = !hf;
            end
            if (mode != 0) exp_pc = fp;
            if (pushed) exp_pc = model_next(w, exp_pc);
            tick();
            #1;
            checks++;
            if ({imem_rmask, imem_addr} !== {4'hf, waddr(exp_pc)}) begin
                errors++;
                $display("FAIL rnd_req: rmask=%h addr=%h want f %h",
                         imem_rmask, imem_addr, waddr(exp_pc));
            end
        end
    endtask

    initial begin
        imem_rdata = '0;
        imem_resp  = 1'b0;
        iq_full    = 1'b0;
        flush      = 1'b0;
        flush_pc   = '0;
        test_reset();
        test_basic();
        test_forward_branch();
        test_full_hold();
        test_flush_wait();
        test_flush_squash();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h1eceb000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 imem_addr  output  32  fetch address, word aligned.
REQ-005 imem_rmask  output  4  4'hf for one cycle per request, else 4'h0.
REQ-006 imem_rdata  input  32  returned instruction word, valid when imem_resp=1.
REQ-007 imem_resp  input  1  one-cycle response pulse, one per request.
REQ-008 iq_full  input  1  instruction queue cannot accept a push this cycle.
REQ-009 iq_push  output  1  push iq_inst/iq_pc/iq_predict into instruction queue.
REQ-010 iq_inst  output  32  instruction word for the decode stage.
REQ-011 iq_pc  output  32  PC of iq_inst.
REQ-012 iq_predict  output  1  predicted-taken flag for iq_inst; feeds decode predict_branch.
REQ-013 flush  input  1  redirect from backend mispredict.
REQ-014 flush_pc  input  32  redirect target, valid when flush=1.

Function
REQ-015 States SHALL be REQ, WAIT, HOLD, SQUASH; one request outstanding maximum.
REQ-016 REQ: imem_rmask=4'hf, imem_addr=pc; next state WAIT, or SQUASH if flush (pc<=flush_pc).
REQ-017 WAIT, no imem_resp: flush -> pc<=flush_pc, SQUASH; else stay.
REQ-018 WAIT, imem_resp and flush: response discarded, no push, pc<=flush_pc, next REQ.
REQ-019 WAIT, imem_resp, no flush, iq_full=0: iq_push=1 same cycle with iq_inst=imem_rdata, iq_pc=pc; pc<=next_pc; next REQ.
REQ-020 WAIT, imem_resp, no flush, iq_full=1: word captured in hold register, no push, next HOLD.
REQ-021 HOLD: flush -> hold discarded, pc<=flush_pc, next REQ; else iq_full=0 -> iq_push=1 from hold register, pc<=next_pc, next REQ; else stay.
REQ-022 SQUASH: imem_resp -> response discarded, next REQ; flush in SQUASH SHALL overwrite pc with newest flush_pc (also on the imem_resp cycle).
REQ-023 flush SHALL have priority over every push; iq_push SHALL be 0 whenever flush=1.
REQ-024 Prediction: iq_predict=1 iff inst[6:0]=7'b1100011 and inst[31]=1 (backward conditional branch).
REQ-025 b_imm = sign-extended {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}; next_pc = iq_predict ? pc+b_imm : pc+4, modulo 2^32.
REQ-026 iq_inst, iq_pc, iq_predict SHALL be don't-care when iq_push=0.
REQ-027 Minimum throughput: one instruction per 2 cycles given immediate response and non-full queue.

Reset
REQ-028 While rst=0: state=REQ, pc=RESET_PC, hold register cleared, iq_push=0; imem_rmask=4'h0 during reset.
REQ-029 First request SHALL issue in the first cycle after rst deasserts, imem_addr=RESET_PC.
REQ-030 Reset mid-request SHALL abandon the outstanding request; a stale imem_resp in the first cycle after reset SHALL be ignored only if state is REQ (no response expected) -> no push.

Verification
REQ-031 Reset release, resp next cycle with 32'h00000013 -> rmask=4'hf at addr 1eceb000, push inst 00000013 pc 1eceb000, next request at 1eceb004.
REQ-032 Resp with 32'hfe000ee3 (beq, offset -4) at pc 1eceb008 -> iq_predict=1, next request at 1eceb004.
REQ-033 Resp with forward branch 32'h00000463 at pc 1eceb000 -> iq_predict=0, next request at 1eceb004.
REQ-034 iq_full=1 for 5 cycles at resp -> no push for 5 cycles, push held word with original pc on first iq_full=0 cycle, then request pc+4.
REQ-035 flush to 1eceb100 while WAIT, resp 3 cycles later -> no push, next request at 1eceb100; flush on resp cycle -> same result.
REQ-036 Second flush to 1eceb200 during SQUASH -> next request at 1eceb200, no push of squashed word.
